// File: rtl/triangle_face_normal_pkg.sv
// rtl/triangle_face_normal_pkg.sv - fixed-point and vector types, saturation helpers
`ifndef FIXED_W
`define FIXED_W 16
`endif
`ifndef FIXED_FRACTION_W
`define FIXED_FRACTION_W 8
`endif

package triangle_face_normal_pkg;

  localparam int FIXED_W          = `FIXED_W;
  localparam int FIXED_FRACTION_W = `FIXED_FRACTION_W;
  localparam int NORMAL_MUL_STEPS = 6;

  typedef logic signed [FIXED_W-1:0] fixed_point_t;

  localparam fixed_point_t FIXED_MAX = {1'b0, {(FIXED_W-1){1'b1}}};
  localparam fixed_point_t FIXED_MIN = {1'b1, {(FIXED_W-1){1'b0}}};

  typedef struct packed {
    fixed_point_t x;
    fixed_point_t y;
    fixed_point_t z;
  } vector_t;

  typedef struct packed {
    logic         ovf;
    fixed_point_t val;
  } sat_result_t;

  // One guard bit is enough: the sum or difference of two W-bit values always fits W+1 bits.
  function automatic sat_result_t sat_clamp(input logic signed [FIXED_W:0] wide);
    sat_result_t r;
    r.ovf = (wide[FIXED_W] != wide[FIXED_W-1]);
    if (!r.ovf) begin
      r.val = wide[FIXED_W-1:0];
    end else if (wide[FIXED_W]) begin
      r.val = FIXED_MIN;
    end else begin
      r.val = FIXED_MAX;
    end
    return r;
  endfunction

  function automatic sat_result_t sat_add(input fixed_point_t a, input fixed_point_t b);
    return sat_clamp({a[FIXED_W-1], a} + {b[FIXED_W-1], b});
  endfunction

  function automatic sat_result_t sat_sub(input fixed_point_t a, input fixed_point_t b);
    return sat_clamp({a[FIXED_W-1], a} - {b[FIXED_W-1], b});
  endfunction

endpackage

// File: rtl/triangle_face_normal_if.sv
// rtl/triangle_face_normal_if.sv - triangle in / face normal out handshake bundle
interface triangle_face_normal_if;
  import triangle_face_normal_pkg::*;

  logic    in_valid;
  logic    in_ready;
  vector_t v0;
  vector_t v1;
  vector_t v2;
  logic    out_valid;
  logic    out_ready;
  vector_t normal;
  logic    overflow;
  logic    degenerate;

  modport master (
    output in_valid, v0, v1, v2, out_ready,
    input  in_ready, out_valid, normal, overflow, degenerate
  );

  modport slave (
    input  in_valid, v0, v1, v2, out_ready,
    output in_ready, out_valid, normal, overflow, degenerate
  );

endinterface

// File: rtl/triangle_face_normal_fixed_mul_sat.sv
// rtl/triangle_face_normal_fixed_mul_sat.sv - combinational saturating fixed-point multiply
module triangle_face_normal_fixed_mul_sat
  import triangle_face_normal_pkg::*;
(
  input  fixed_point_t a,
  input  fixed_point_t b,
  output fixed_point_t result,
  output logic         overflow
);

  localparam int PROD_W = 2 * FIXED_W;

  logic signed [PROD_W-1:0]      product;
  logic signed [PROD_W-1:0]      shifted;
  logic [PROD_W-FIXED_W:0]       upper;

  always_comb begin
    product  = PROD_W'(a) * PROD_W'(b);
    shifted  = product >>> FIXED_FRACTION_W;
    // Fits only when every bit above the result sign bit matches it.
    upper    = shifted[PROD_W-1:FIXED_W-1];
    overflow = !((&upper) || !(|upper));
    if (!overflow) begin
      result = shifted[FIXED_W-1:0];
    end else if (shifted[PROD_W-1]) begin
      result = FIXED_MIN;
    end else begin
      result = FIXED_MAX;
    end
  end

endmodule

// File: rtl/triangle_face_normal.sv
// rtl/triangle_face_normal.sv - unnormalised face normal (v1-v0)x(v2-v0), one shared
// saturating multiplier iterated over six steps
module triangle_face_normal
  import triangle_face_normal_pkg::*;
#(
  parameter bit FLIP_WINDING = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  triangle_face_normal_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EDGE = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] LAST_STEP = 3'(NORMAL_MUL_STEPS - 1);

  logic [1:0]   state_q, state_d;
  logic [2:0]   step_q, step_d;
  vector_t      v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  vector_t      e1_q, e1_d, e2_q, e2_d;
  fixed_point_t p_q, p_d;
  vector_t      normal_q, normal_d;
  logic         overflow_q, overflow_d;
  logic         degenerate_q, degenerate_d;

  fixed_point_t mul_a, mul_b, mul_result;
  logic         mul_ovf;
  sat_result_t  sa_x, sa_y, sa_z, sb_x, sb_y, sb_z, diff;
  vector_t      edge_a, edge_b;

  // Pairs 2k and 2k+1 form the two terms of normal component k.
  always_comb begin
    mul_a = e1_q.y;
    mul_b = e2_q.x;
    case (step_q)
      3'd0:    begin mul_a = e1_q.y; mul_b = e2_q.z; end
      3'd1:    begin mul_a = e1_q.z; mul_b = e2_q.y; end
      3'd2:    begin mul_a = e1_q.z; mul_b = e2_q.x; end
      3'd3:    begin mul_a = e1_q.x; mul_b = e2_q.z; end
      3'd4:    begin mul_a = e1_q.x; mul_b = e2_q.y; end
      default: begin mul_a = e1_q.y; mul_b = e2_q.x; end
    endcase
  end

  triangle_face_normal_fixed_mul_sat u_mul (
    .a        (mul_a),
    .b        (mul_b),
    .result   (mul_result),
    .overflow (mul_ovf)
  );

  always_comb begin
    sa_x   = sat_sub(v1_q.x, v0_q.x);
    sa_y   = sat_sub(v1_q.y, v0_q.y);
    sa_z   = sat_sub(v1_q.z, v0_q.z);
    sb_x   = sat_sub(v2_q.x, v0_q.x);
    sb_y   = sat_sub(v2_q.y, v0_q.y);
    sb_z   = sat_sub(v2_q.z, v0_q.z);
    edge_a = {sa_x.val, sa_y.val, sa_z.val};
    edge_b = {sb_x.val, sb_y.val, sb_z.val};
    diff   = sat_sub(p_q, mul_result);
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    v0_d         = v0_q;
    v1_d         = v1_q;
    v2_d         = v2_q;
    e1_d         = e1_q;
    e2_d         = e2_q;
    p_d          = p_q;
    normal_d     = normal_q;
    overflow_d   = overflow_q;
    degenerate_d = degenerate_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          v0_d         = bus.v0;
          v1_d         = bus.v1;
          v2_d         = bus.v2;
          overflow_d   = 1'b0;
          degenerate_d = 1'b0;
          state_d      = ST_EDGE;
        end
      end
      ST_EDGE: begin
        e1_d       = FLIP_WINDING ? edge_b : edge_a;
        e2_d       = FLIP_WINDING ? edge_a : edge_b;
        overflow_d = overflow_q | sa_x.ovf | sa_y.ovf | sa_z.ovf
                                | sb_x.ovf | sb_y.ovf | sb_z.ovf;
        step_d     = 3'd0;
        state_d    = ST_MUL;
      end
      ST_MUL: begin
        if (!step_q[0]) begin
          p_d        = mul_result;
          overflow_d = overflow_q | mul_ovf;
        end else begin
          overflow_d = overflow_q | mul_ovf | diff.ovf;
          case (step_q[2:1])
            2'd0:    normal_d.x = diff.val;
            2'd1:    normal_d.y = diff.val;
            default: normal_d.z = diff.val;
          endcase
        end
        if (step_q == LAST_STEP) begin
          // z is still in flight here, so take it from the subtractor directly.
          degenerate_d = (normal_q.x == '0) && (normal_q.y == '0) && (diff.val == '0);
          state_d      = ST_DONE;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      default: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      step_q       <= 3'd0;
      v0_q         <= '0;
      v1_q         <= '0;
      v2_q         <= '0;
      e1_q         <= '0;
      e2_q         <= '0;
      p_q          <= '0;
      normal_q     <= '0;
      overflow_q   <= 1'b0;
      degenerate_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      v0_q         <= v0_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      e1_q         <= e1_d;
      e2_q         <= e2_d;
      p_q          <= p_d;
      normal_q     <= normal_d;
      overflow_q   <= overflow_d;
      degenerate_q <= degenerate_d;
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.normal     = normal_q;
  assign bus.overflow   = overflow_q;
  assign bus.degenerate = degenerate_q;

endmodule
